// File: rtl/ofm_relu_pool.sv
// rtl/ofm_relu_pool.sv - ReLU + 2x2 stride-2 max-pool of a streamed 4-channel OFM into a readable pooled map
// Raster-ordered writes only; a half-width line buffer holds the even-row horizontal maxima.
module ofm_relu_pool #(
  parameter int DW    = 32,
  parameter int MAP_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           wrofm,
  input  logic [2*$clog2(MAP_W)-1:0]     ofmaddr,
  input  logic [DW-1:0]                  Dataofm1,
  input  logic [DW-1:0]                  Dataofm2,
  input  logic [DW-1:0]                  Dataofm3,
  input  logic [DW-1:0]                  Dataofm4,
  input  logic [2*$clog2(MAP_W)-3:0]     rd_addr,
  output logic [DW-1:0]                  rd_data1,
  output logic [DW-1:0]                  rd_data2,
  output logic [DW-1:0]                  rd_data3,
  output logic [DW-1:0]                  rd_data4,
  output logic                           busy,
  output logic                           done,
  output logic                           valid,
  output logic                           order_err
);

  localparam int LW    = $clog2(MAP_W);
  localparam int AW    = 2 * LW;
  localparam int PAW   = AW - 2;
  localparam int HW    = MAP_W / 2;
  localparam int NPOOL = HW * HW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAP_W * MAP_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FULL} stateT;

  stateT stateQ, stateD;
  logic [AW-1:0] expQ;

  logic [DW-1:0] pairQ [4];
  logic [DW-1:0] lineQ [4][HW];
  logic [DW-1:0] mem   [4][NPOOL];

  logic [DW-1:0] din   [4];
  logic [DW-1:0] reluV [4];
  logic [DW-1:0] hMax  [4];
  logic [DW-1:0] vMax  [4];

  logic          inRun, accept, badWrite, lastAccept;
  logic [LW-1:0] row, col;
  logic [LW-2:0] halfCol;
  logic [PAW-1:0] poolAddr;

  assign din[0] = Dataofm1;
  assign din[1] = Dataofm2;
  assign din[2] = Dataofm3;
  assign din[3] = Dataofm4;

  assign row      = ofmaddr[AW-1:LW];
  assign col      = ofmaddr[LW-1:0];
  assign halfCol  = col[LW-1:1];
  assign poolAddr = {row[LW-1:1], halfCol};

  // start has priority over any write presented in the same cycle
  assign inRun      = (stateQ == RUN) && !start;
  assign accept     = inRun && wrofm && (ofmaddr == expQ);
  assign badWrite   = inRun && wrofm && (ofmaddr != expQ);
  assign lastAccept = accept && (ofmaddr == LAST_ADDR);
  assign busy       = (stateQ == RUN);

  always_comb begin
    stateD = stateQ;
    if (start)
      stateD = RUN;
    else if (lastAccept)
      stateD = FULL;
  end

  // Post-ReLU values are non-negative, so plain unsigned compares give the max
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      reluV[c] = din[c][DW-1] ? '0 : din[c];
      hMax[c]  = (pairQ[c] > reluV[c]) ? pairQ[c] : reluV[c];
      vMax[c]  = (lineQ[c][halfCol] > hMax[c]) ? lineQ[c][halfCol] : hMax[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      expQ      <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
      order_err <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        pairQ[c] <= '0;
        for (int i = 0; i < HW; i++)
          lineQ[c][i] <= '0;
      end
    end else begin
      stateQ <= stateD;
      done   <= lastAccept;
      if (start) begin
        expQ      <= '0;
        valid     <= 1'b0;
        order_err <= 1'b0;
      end else begin
        if (accept)     expQ      <= expQ + AW'(1);
        if (lastAccept) valid     <= 1'b1;
        if (badWrite)   order_err <= 1'b1;
      end
      if (accept) begin
        for (int c = 0; c < 4; c++) begin
          if (!col[0])
            pairQ[c] <= reluV[c];
          else if (!row[0])
            lineQ[c][halfCol] <= hMax[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && row[0] && col[0]) begin
      for (int c = 0; c < 4; c++)
        mem[c][poolAddr] <= vMax[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_data3 <= '0;
      rd_data4 <= '0;
    end else begin
      rd_data1 <= mem[0][rd_addr];
      rd_data2 <= mem[1][rd_addr];
      rd_data3 <= mem[2][rd_addr];
      rd_data4 <= mem[3][rd_addr];
    end
  end

endmodule

// File: tb/tb_ofm_relu_pool.sv
// tb/tb_ofm_relu_pool.sv - directed bench for ofm_relu_pool with a whole-map pooling model
// The model pools a completed 16x16 map in one pass; a negedge process compares every cycle.
module tb_ofm_relu_pool;

  logic        clk = 1'b0;
  logic        rst, start, wrofm;
  logic [7:0]  ofmaddr;
  logic [31:0] Dataofm1, Dataofm2, Dataofm3, Dataofm4;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data1, rd_data2, rd_data3, rd_data4;
  logic        busy, done, valid, order_err;

  ofm_relu_pool #(.DW(32), .MAP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .wrofm(wrofm), .ofmaddr(ofmaddr),
    .Dataofm1(Dataofm1), .Dataofm2(Dataofm2), .Dataofm3(Dataofm3), .Dataofm4(Dataofm4),
    .rd_addr(rd_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3), .rd_data4(rd_data4),
    .busy(busy), .done(done), .valid(valid), .order_err(order_err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;
  int doneCnt = 0;

  logic [31:0] pix    [4][256];
  logic [31:0] pooled [4][64];
  bit mCollect = 0, mValid = 0, mErr = 0, mDone = 0, rdOk = 0;
  int mNext = 0;
  int rdA = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVec++;
    if (act !== expv) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] pixVal(input int kind, input int c, input int a);
    case (kind)
      0:       return (c == 0) ? 32'(a) : 32'(-a);
      1:       return (c == 2 && a == 34) ? 32'h7FFF_FFFF : 32'h0;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic poolMap();
    for (int c = 0; c < 4; c++)
      for (int pr = 0; pr < 8; pr++)
        for (int pc = 0; pc < 8; pc++) begin
          logic [31:0] m, v;
          m = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = pix[c][(2*pr+dy)*16 + 2*pc + dx];
              if (v[31]) v = 0;
              if (v > m) m = v;
            end
          pooled[c][pr*8+pc] = m;
        end
  endtask

  always @(posedge clk) begin
    bit pre;
    pre   = mValid;
    mDone = 0;
    rdA   = int'(rd_addr);
    if (rst) begin
      mCollect = 0; mValid = 0; mErr = 0; mNext = 0;
    end else if (start) begin
      mCollect = 1; mValid = 0; mErr = 0; mNext = 0;
    end else if (mCollect && wrofm) begin
      if (int'(ofmaddr) == mNext) begin
        pix[0][mNext] = Dataofm1;
        pix[1][mNext] = Dataofm2;
        pix[2][mNext] = Dataofm3;
        pix[3][mNext] = Dataofm4;
        if (mNext == 255) begin
          mCollect = 0; mValid = 1; mDone = 1;
          poolMap();
        end
        mNext++;
      end else begin
        mErr = 1;
      end
    end
    rdOk = pre && mValid;
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, mCollect});
    check("done", {31'b0, done}, {31'b0, mDone});
    check("valid", {31'b0, valid}, {31'b0, mValid});
    check("order_err", {31'b0, order_err}, {31'b0, mErr});
    if (done) doneCnt++;
    if (rdOk) begin
      check("rd_data1", rd_data1, pooled[0][rdA]);
      check("rd_data2", rd_data2, pooled[1][rdA]);
      check("rd_data3", rd_data3, pooled[2][rdA]);
      check("rd_data4", rd_data4, pooled[3][rdA]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int kind, input int a);
    wrofm    = 1'b1;
    ofmaddr  = 8'(a);
    Dataofm1 = pixVal(kind, 0, a);
    Dataofm2 = pixVal(kind, 1, a);
    Dataofm3 = pixVal(kind, 2, a);
    Dataofm4 = pixVal(kind, 3, a);
    tick();
    wrofm = 1'b0;
  endtask

  task automatic writeRange(input int kind, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) wr(kind, a);
  endtask

  task automatic readAt(input int a);
    rd_addr = 6'(a);
    tick();
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) readAt(a);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; wrofm = 1'b0; ofmaddr = '0; rd_addr = '0;
    Dataofm1 = '0; Dataofm2 = '0; Dataofm3 = '0; Dataofm4 = '0;
    tick(); tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset valid", {31'b0, valid}, 32'd0);
    check("reset rd_data1", rd_data1, 32'd0);
    check("reset rd_data4", rd_data4, 32'd0);
    rst = 1'b0;
    tick();

    writeRange(0, 0, 255);
    tick();
    check("idle writes valid", {31'b0, valid}, 32'd0);
    check("idle writes done count", 32'(doneCnt), 32'd0);

    doStart();
    check("busy after start", {31'b0, busy}, 32'd1);
    writeRange(0, 0, 255);
    check("done pulse", {31'b0, done}, 32'd1);
    tick();
    check("done once", 32'(doneCnt), 32'd1);
    check("valid after map", {31'b0, valid}, 32'd1);
    check("busy after map", {31'b0, busy}, 32'd0);
    readAt(0);
    check("ramp addr0 ch1", rd_data1, 32'd17);
    check("ramp addr0 ch2", rd_data2, 32'd0);
    check("ramp addr0 ch4", rd_data4, 32'd0);
    readAt(63);
    check("ramp addr63 ch1", rd_data1, 32'd255);
    sweep();

    writeRange(2, 0, 255);
    readAt(0);
    check("full writes ignored", rd_data1, 32'd17);
    check("full writes no done", 32'(doneCnt), 32'd1);
    sweep();

    doStart();
    writeRange(1, 0, 255);
    tick();
    readAt(9);
    check("peak addr9 ch3", rd_data3, 32'h7FFF_FFFF);
    check("peak addr9 ch1", rd_data1, 32'd0);
    sweep();

    doStart();
    writeRange(2, 0, 255);
    tick();
    readAt(5);
    check("negsat addr5 ch2", rd_data2, 32'd0);
    sweep();

    doStart();
    wr(0, 0);
    wr(0, 2);
    check("order_err set", {31'b0, order_err}, 32'd1);
    d0 = doneCnt;
    wr(0, 1);
    writeRange(0, 2, 255);
    tick();
    check("order recover done", 32'(doneCnt - d0), 32'd1);
    check("order_err sticky", {31'b0, order_err}, 32'd1);
    readAt(0);
    check("order recover addr0", rd_data1, 32'd17);
    doStart();
    check("order_err cleared", {31'b0, order_err}, 32'd0);

    writeRange(0, 0, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid-run busy", {31'b0, busy}, 32'd0);
    check("rst mid-run valid", {31'b0, valid}, 32'd0);
    d0 = doneCnt;
    doStart();
    writeRange(0, 0, 255);
    tick(); tick();
    check("after rst done once", 32'(doneCnt - d0), 32'd1);
    readAt(63);
    check("after rst addr63", rd_data1, 32'd255);
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/ofm_relu_pool.md
Name: ofm_relu_pool

Overview:
- Sits directly downstream of the layer-1 datapath, on its OFM write stream: write strobe, 8-bit OFM address and four 32-bit channel outputs.
- Applies ReLU and 2x2 stride-2 max-pooling to all four channels on the fly, using a half-width line buffer.
- Stores the 8x8 pooled maps and serves them through a registered read port addressed like the layer-2 input buffer (6-bit address).

Parameters:
- DW, 32: channel data width, signed two's complement.
- MAP_W, 16: OFM side length (square map, power of two, ≤16). OFM address width is AW = 2*log2(MAP_W) = 8. Pooled address width is PAW = AW-2 = 6.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  arms block for a new map; clears valid/order_err
- wrofm  in  1  OFM write strobe from layer-1 datapath
- ofmaddr  in  AW  raster address of current OFM pixel (row*MAP_W+col)
- Dataofm1..Dataofm4  in  DW each  channel 1..4 pixel values
- rd_addr  in  PAW  pooled read address (prow*(MAP_W/2)+pcol)
- rd_data1..rd_data4  out  DW each  pooled values, registered
- busy  out  1  high while collecting a map
- done  out  1  one-cycle pulse when final pooled entry is written
- valid  out  1  level; pooled memory holds a complete map
- order_err  out  1  sticky; out-of-order write seen

Behaviour:
- One clock, rst synchronous active-high. Reset: state IDLE, busy=0, done=0, valid=0, order_err=0, rd_data1..4=0, expected address exp=0, pair/line registers 0. Pooled memory contents are not reset.
- FSM states: IDLE, RUN, FULL.
  - IDLE/FULL + start -> RUN. exp=0, valid=0, order_err=0.
  - RUN + accepted write with ofmaddr==MAP_W*MAP_W-1 -> FULL. done=1 for the next cycle only, valid=1 from the next cycle.
  - start in RUN restarts: exp=0, partial data discarded.
- busy = (state==RUN).
- Accept rule, applied in RUN only: wrofm=1 and ofmaddr==exp. On accept, exp increments.
  - wrofm in IDLE/FULL is ignored.
  - In RUN, wrofm with ofmaddr!=exp: order_err=1 (sticky until start/rst), write dropped, exp unchanged.
  - start and wrofm in the same cycle: start wins, write dropped.
- ReLU per channel: r = (x[DW-1]) ? 0 : x. All max compares are on post-ReLU values, so they are non-negative.
- Pooling, per channel, for an accepted pixel at row=ofmaddr/MAP_W and col=ofmaddr%MAP_W:
  - Even col: pair register <= r.
  - Odd col: h = max(pair, r).
  - Even row, odd col: line[col/2] <= h.
  - Odd row, odd col: mem[(row/2)*(MAP_W/2)+col/2] <= max(line[col/2], h), written at the same clock edge.
  - Ties: either operand (equal values).
- Pooled memory: (MAP_W/2)^2 entries x 4 channels x DW. A write occurs only on odd-row/odd-col accepts.
- Read port: rd_dataN <= memN[rd_addr] every cycle, 1-cycle latency, regardless of state.
  - Same-cycle read and write to the same address returns the old value.
  - Data is meaningful only while valid=1.
- rst mid-RUN: returns to IDLE at that edge. valid stays 0 until a full map completes after the next start.

Test Plan:
- Map of ch1 = ofmaddr value, ch2..4 = -ofmaddr, written in order after start. Then rd_addr=0 -> rd_data1=17, rd_data2..4=0. rd_addr=63 -> rd_data1=255. done pulses exactly once, one cycle after addr 255 is accepted. valid=1, busy=0.
- Single peak: all channels 0 except ch3 at addr 34 (row 2, col 2) = 0x7FFF_FFFF. Pooled addr 9 -> rd_data3=0x7FFF_FFFF. All other entries are 0.
- Negative saturation: every pixel 0x8000_0000 on all channels -> every pooled entry is 0.
- Order error: in RUN, write addr 0, then addr 2 -> order_err=1 and exp stays 1. Writing addr 1 is then accepted. A new start clears order_err.
- Writes ignored in IDLE (before start) and in FULL: a 256-write map in IDLE leaves valid=0 and done never pulses. Writes after valid leave the stored values unchanged.
- rst asserted after addr 100 -> busy=0, valid=0. Then start plus a full map -> correct results, done=1 once.
